// File: rtl/status_frame_tx.sv
// Telemetry frame transmitter: captures heading/obstacle/state on request and
// streams a 12-byte ASCII frame ("STddd.d,B,C;") into a UART via tx_en/tx_busy.
module status_frame_tx #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk0,
  input  logic        rst_n,
  input  logic        send_req,
  input  logic [11:0] heading,
  input  logic [3:0]  barri,
  input  logic [3:0]  car_state,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_LOAD, S_ACK, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  idx_reg, idx_next;
  logic [1:0]  stage_reg, stage_next;
  logic [11:0] rem_reg, rem_next;
  logic [3:0]  d2_reg, d2_next, d1_reg, d1_next, d0_reg, d0_next;
  logic [3:0]  barri_reg, barri_next, car_reg, car_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic        tx_en_reg, tx_en_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic [11:0] heading_clamped;
  logic [11:0] weight;

  function automatic logic [7:0] dec_char(input logic [3:0] v);
    return 8'd48 + {4'd0, v};
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? (8'd48 + {4'd0, v}) : (8'd55 + {4'd0, v});
  endfunction

  // After conversion the remainder holds the tenths digit (always < 10).
  function automatic logic [7:0] frame_byte(
    input logic [3:0] i, input logic [3:0] a2, input logic [3:0] a1,
    input logic [3:0] a0, input logic [3:0] at, input logic [3:0] b,
    input logic [3:0] c);
    case (i)
      4'd0:    return 8'd83;
      4'd1:    return 8'd84;
      4'd2:    return dec_char(a2);
      4'd3:    return dec_char(a1);
      4'd4:    return dec_char(a0);
      4'd5:    return 8'd46;
      4'd6:    return dec_char(at);
      4'd7:    return 8'd44;
      4'd8:    return hex_char(b);
      4'd9:    return 8'd44;
      4'd10:   return hex_char(c);
      default: return 8'd59;
    endcase
  endfunction

  assign heading_clamped = (heading > 12'd3599) ? 12'd3599 : heading;

  always_comb begin
    case (stage_reg)
      2'd0:    weight = 12'd1000;
      2'd1:    weight = 12'd100;
      default: weight = 12'd10;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    stage_next   = stage_reg;
    rem_next     = rem_reg;
    d2_next      = d2_reg;
    d1_next      = d1_reg;
    d0_next      = d0_reg;
    barri_next   = barri_reg;
    car_next     = car_reg;
    cnt_next     = cnt_reg;
    tx_data_next = tx_data_reg;
    tx_en_next   = 1'b0;
    done_next    = 1'b0;
    err_next     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // A request coinciding with the end pulse of the previous frame is dropped.
        if (send_req && !done_reg && !err_reg) begin
          rem_next   = heading_clamped;
          barri_next = barri;
          car_next   = car_state;
          d2_next    = 4'd0;
          d1_next    = 4'd0;
          d0_next    = 4'd0;
          stage_next = 2'd0;
          idx_next   = 4'd0;
          state_next = S_CONV;
        end
      end
      S_CONV: begin
        if (rem_reg >= weight) begin
          rem_next = rem_reg - weight;
          case (stage_reg)
            2'd0:    d2_next = d2_reg + 4'd1;
            2'd1:    d1_next = d1_reg + 4'd1;
            default: d0_next = d0_reg + 4'd1;
          endcase
        end else if (stage_reg == 2'd2) begin
          state_next   = S_LOAD;
          tx_en_next   = 1'b1;
          tx_data_next = frame_byte(idx_reg, d2_reg, d1_reg, d0_reg,
                                    rem_reg[3:0], barri_reg, car_reg);
        end else begin
          stage_next = stage_reg + 2'd1;
        end
      end
      S_LOAD: begin
        cnt_next   = 16'd0;
        state_next = S_ACK;
      end
      S_ACK: begin
        if (tx_busy) begin
          state_next = S_DONE;
        end else if (cnt_reg == 16'(ACK_TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      S_DONE: begin
        if (!tx_busy) begin
          if (idx_reg == 4'd11) begin
            done_next  = 1'b1;
            state_next = S_IDLE;
          end else begin
            idx_next     = idx_reg + 4'd1;
            state_next   = S_LOAD;
            tx_en_next   = 1'b1;
            tx_data_next = frame_byte(idx_reg + 4'd1, d2_reg, d1_reg, d0_reg,
                                      rem_reg[3:0], barri_reg, car_reg);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      idx_reg     <= 4'd0;
      stage_reg   <= 2'd0;
      rem_reg     <= 12'd0;
      d2_reg      <= 4'd0;
      d1_reg      <= 4'd0;
      d0_reg      <= 4'd0;
      barri_reg   <= 4'd0;
      car_reg     <= 4'd0;
      cnt_reg     <= 16'd0;
      tx_data_reg <= 8'd0;
      tx_en_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      stage_reg   <= stage_next;
      rem_reg     <= rem_next;
      d2_reg      <= d2_next;
      d1_reg      <= d1_next;
      d0_reg      <= d0_next;
      barri_reg   <= barri_next;
      car_reg     <= car_next;
      cnt_reg     <= cnt_next;
      tx_data_reg <= tx_data_next;
      tx_en_reg   <= tx_en_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  assign tx_data    = tx_data_reg;
  assign tx_en      = tx_en_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;
  assign frame_err  = err_reg;

endmodule

// File: tb/tb_status_frame_tx.sv
// Bench for status_frame_tx: directed and random frames against an arithmetic
// frame model, with a responsive (or dead) UART model on tx_en/tx_busy.
module tb_status_frame_tx;
  localparam int ACK_TO = 15;

  logic        clk0 = 1'b0;
  logic        rst_n = 1'b0;
  logic        send_req = 1'b0;
  logic [11:0] heading = 12'd0;
  logic [3:0]  barri = 4'd0;
  logic [3:0]  car_state = 4'd0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_en, busy, frame_done, frame_err;

  status_frame_tx #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clk0(clk0), .rst_n(rst_n), .send_req(send_req), .heading(heading),
    .barri(barri), .car_state(car_state), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_en(tx_en), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk0 = ~clk0;

  int cyc = 0;
  always @(posedge clk0) cyc <= cyc + 1;

  // UART model: tx_busy rises the cycle after tx_en and stays high hold cycles.
  int uart_mode = 1;
  bit rand_hold = 1'b0;
  int hold_cnt = 0;
  always @(posedge clk0) begin
    if (tx_en && uart_mode == 1) begin
      tx_busy  <= 1'b1;
      hold_cnt <= rand_hold ? int'($urandom_range(1, 10)) : 10;
    end else if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
      if (hold_cnt == 1) tx_busy <= 1'b0;
    end
  end

  logic [7:0] got[$];
  int done_cnt = 0, err_cnt = 0;
  int busy_rise_cyc = 0, first_tx_cyc = 0, err_cyc = 0;
  logic busy_prev = 1'b0, busy_at_done = 1'b1, busy_at_err = 1'b1;
  always @(negedge clk0) begin
    if (tx_en) begin
      if (got.size() == 0) first_tx_cyc = cyc;
      got.push_back(tx_data);
    end
    if (busy && !busy_prev) busy_rise_cyc = cyc;
    busy_prev = busy;
    if (frame_done) begin done_cnt++; busy_at_done = busy; end
    if (frame_err) begin err_cnt++; err_cyc = cyc; busy_at_err = busy; end
  end

  int checks = 0, passes = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Reference frame built from the decimal/hex rules directly.
  logic [7:0] exp_f[12];
  int exp_conv;
  function automatic logic [7:0] hexc(input int v);
    return (v < 10) ? 8'(48 + v) : 8'(55 + v);
  endfunction
  task automatic build_exp(input int h, input int b, input int c);
    int hc, q;
    hc = (h > 3599) ? 3599 : h;
    q = hc / 10;
    exp_f[0] = 8'd83; exp_f[1] = 8'd84;
    exp_f[2] = 8'(48 + q / 100);
    exp_f[3] = 8'(48 + (q / 10) % 10);
    exp_f[4] = 8'(48 + q % 10);
    exp_f[5] = 8'd46;
    exp_f[6] = 8'(48 + hc % 10);
    exp_f[7] = 8'd44; exp_f[8] = hexc(b); exp_f[9] = 8'd44;
    exp_f[10] = hexc(c); exp_f[11] = 8'd59;
    exp_conv = q / 100 + (q / 10) % 10 + q % 10 + 3;
  endtask

  task automatic check_frame(input string tag);
    check({tag, " nbytes"}, got.size(), 12);
    for (int i = 0; i < 12; i++)
      check($sformatf("%s byte%0d", tag, i), (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF, {24'd0, exp_f[i]});
  endtask

  task automatic start(input int h, input int b, input int c);
    @(negedge clk0);
    got.delete();
    heading = 12'(h); barri = 4'(b); car_state = 4'(c); send_req = 1'b1;
    @(negedge clk0);
    send_req = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk0);
      if (frame_done || frame_err) begin ok = 1'b1; break; end
    end
    @(negedge clk0);
  endtask

  task automatic run_full(input int h, input int b, input int c, input string tag);
    bit ok;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    build_exp(h, b, c);
    start(h, b, c);
    wait_end(ok);
    check({tag, " ended"}, ok, 1);
    check_frame(tag);
    check({tag, " done"}, done_cnt - d0, 1);
    check({tag, " err"}, err_cnt - e0, 0);
    check({tag, " conv"}, first_tx_cyc - busy_rise_cyc, exp_conv);
    check({tag, " busy@done"}, busy_at_done, 0);
    $display("frame %s heading=%0d barri=%0d state=%0d bytes=%0d conv=%0d", tag, h, b, c,
             got.size(), first_tx_cyc - busy_rise_cyc);
  endtask

  initial begin
    bit ok;
    int d0, e0, h, b, c;
    repeat (3) @(negedge clk0);
    check("rst tx_data", tx_data, 0);
    check("rst tx_en", tx_en, 0);
    check("rst busy", busy, 0);
    check("rst frame_done", frame_done, 0);
    check("rst frame_err", frame_err, 0);
    rst_n = 1'b1;

    run_full(1234, 3, 13, "t1234");
    run_full(57, 15, 0, "t57");
    run_full(4000, 10, 7, "tclamp");
    run_full(0, 0, 15, "tzero");
    rand_hold = 1'b1;
    for (int k = 0; k < 6; k++) begin
      h = int'($urandom_range(0, 4095)); b = int'($urandom_range(0, 15)); c = int'($urandom_range(0, 15));
      run_full(h, b, c, $sformatf("rnd%0d", k));
    end
    rand_hold = 1'b0;

    // Extra requests and input changes mid-frame, plus a request on the done cycle.
    d0 = done_cnt;
    build_exp(2718, 9, 10);
    start(2718, 9, 10);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(3, 20)) @(negedge clk0);
      heading = 12'd100; barri = 4'd0; car_state = 4'd0; send_req = 1'b1;
      @(negedge clk0);
      send_req = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk0);
      if (frame_done) begin ok = 1'b1; break; end
    end
    heading = 12'd555; send_req = 1'b1;
    @(negedge clk0);
    send_req = 1'b0;
    repeat (40) @(negedge clk0);
    check("intf ended", ok, 1);
    check_frame("intf");
    check("intf done", done_cnt - d0, 1);
    check("intf busy after", busy, 0);
    $display("frame intf bytes=%0d done=%0d", got.size(), done_cnt - d0);

    // Dead UART: acknowledge timeout after the first byte.
    uart_mode = 0;
    d0 = done_cnt; e0 = err_cnt;
    start(1000, 1, 1);
    wait_end(ok);
    check("tmo ended", ok, 1);
    check("tmo err", err_cnt - e0, 1);
    check("tmo done", done_cnt - d0, 0);
    check("tmo nbytes", got.size(), 1);
    check("tmo byte0", (got.size() > 0) ? {24'd0, got[0]} : 32'hFFFF, 83);
    check("tmo latency", err_cyc - first_tx_cyc, ACK_TO + 1);
    check("tmo busy@err", busy_at_err, 0);
    repeat (30) @(negedge clk0);
    check("tmo no more tx", got.size(), 1);
    $display("frame timeout bytes=%0d latency=%0d", got.size(), err_cyc - first_tx_cyc);
    uart_mode = 1;

    // Reset while the 6th byte is in DONE.
    d0 = done_cnt; e0 = err_cnt;
    start(2222, 5, 11);
    for (int i = 0; i < 3000 && got.size() < 6; i++) @(negedge clk0);
    repeat (4) @(negedge clk0);
    rst_n = 1'b0;
    @(negedge clk0);
    rst_n = 1'b1;
    check("mid tx_data", tx_data, 0);
    check("mid tx_en", tx_en, 0);
    check("mid busy", busy, 0);
    check("mid frame_done", frame_done, 0);
    check("mid frame_err", frame_err, 0);
    repeat (40) @(negedge clk0);
    check("mid nbytes", got.size(), 6);
    check("mid no done", done_cnt - d0, 0);
    check("mid no err", err_cnt - e0, 0);
    $display("frame midreset bytes=%0d", got.size());
    run_full(2222, 5, 11, "postrst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/status_frame_tx.md
# status_frame_tx

Telemetry frame transmitter for the HC-05 Bluetooth link. It is the outbound counterpart of the `;`-terminated command parser that feeds the car state machine. On request, it captures the current compass heading, obstacle grid count and drive-state code, then converts the heading to ASCII decimal. It streams a fixed 12-byte ASCII frame into the byte-level UART transmitter through a pulse/busy handshake.

## Interface
Parameters:
- ACK_TIMEOUT, default 15: cycles to wait for `tx_busy` to rise after a `tx_en` pulse before the frame is aborted.

Ports:
- clk0  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- send_req  in  1  one-cycle request to send a frame.
- heading  in  12  heading in tenths of a degree, nominal range 0..3599.
- barri  in  4  obstacle grid count, 0..15.
- car_state  in  4  drive-state code, 0..15.
- tx_busy  in  1  high while the UART transmitter is shifting a byte.
- tx_data  out  8  byte offered to the UART.
- tx_en  out  1  one-cycle strobe; `tx_data` is valid in the same cycle.
- busy  out  1  high from request acceptance until frame end or abort.
- frame_done  out  1  one-cycle pulse after the last byte completes.
- frame_err  out  1  one-cycle pulse on acknowledge timeout.

## Operation
- Frame layout, 12 bytes, in send order:
  - `S` (83), `T` (84)
  - D2, D1, D0 (hundreds, tens and units of heading/10)
  - `.` (46)
  - DT (heading mod 10)
  - `,` (44), B, `,` (44), C
  - `;` (59)
- Digit encoding:
  - D2, D1, D0 and DT are ASCII `0`..`9` (48 + value), with leading zeros kept. Example: 57 encodes as `005.7`.
  - B and C are upper-case hex: values 0..9 map to 48+v; values 10..15 map to 55+v (`A`..`F`).
- Input capture and clamping:
  - `heading` > 3599 is clamped to 3599 at capture.
  - All three inputs are latched in the cycle `send_req` is accepted.
  - Later input changes do not affect the frame in flight.
- States:
  - IDLE: `busy`=0. `send_req`=1 → latch inputs, go to CONV.
  - CONV: subtractive binary-to-decimal conversion on the 12-bit latched value.
    - Stage weight 1000, then 100, then 10.
    - Each cycle: if remainder ≥ weight, subtract weight and increment the stage digit; otherwise move to the next stage.
    - After the weight-10 stage exits, the remainder is DT. Go to LOAD.
    - Cycles spent in CONV = D2+D1+D0+3.
  - LOAD: drive `tx_data` = byte[idx] and `tx_en`=1 for exactly one cycle. Clear the timeout counter. Go to ACK.
  - ACK: wait for `tx_busy`=1, then go to DONE.
    - The counter increments each ACK cycle.
    - Counter reaching ACK_TIMEOUT with `tx_busy` still 0 → pulse `frame_err`, go to IDLE.
  - DONE: wait for `tx_busy`=0.
    - If idx=11: pulse `frame_done`, go to IDLE.
    - Otherwise: idx+1, go to LOAD.
- `send_req` while `busy`=1 is ignored. It is not queued.
- `send_req` in the same cycle that `frame_done` or `frame_err` pulses is ignored. A new frame is accepted no earlier than the following cycle.
- `tx_busy` is not examined in LOAD. The UART is guaranteed idle at that point because DONE only exits on `tx_busy`=0.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, idx=0.
  - Outputs: `tx_data`=0, `tx_en`=0, `busy`=0, `frame_done`=0, `frame_err`=0.
  - Digit registers and latched inputs are cleared to 0.
- Reset mid-frame aborts immediately. `tx_en` is 0 from that edge on, and no `frame_done` or `frame_err` is produced.
- Acceptance: `send_req` high at edge N → `busy`=1 from N+1. CONV occupies N+1 .. N+D2+D1+D0+3.
- First `tx_en` lands in the cycle right after CONV ends (LOAD). With an ideal UART, consecutive `tx_en` pulses are separated by 1 (LOAD) + ACK cycles + DONE cycles.
- `tx_busy` rising in the first ACK cycle costs exactly one ACK cycle.
- `frame_done` and `busy` falling occur on the same edge: `frame_done`=1 and `busy`=0 in the same cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Request with heading=1234, barri=3, car_state=13, and a UART model that raises `tx_busy` one cycle after `tx_en` and holds it 10 cycles:
  - Bytes sent are `ST123.4,3,D;`.
  - CONV lasts 9 cycles.
  - Exactly 12 `tx_en` pulses, then one `frame_done`.
- heading=57, barri=15, car_state=0 → frame `ST005.7,F,0;`.
- heading=4000 → clamped; frame `ST359.9,…`. Heading 0 → `ST000.0,…`, with CONV lasting 3 cycles.
- Extra `send_req` pulses during a frame, plus heading changed mid-frame:
  - Only one frame is sent, carrying the values latched at acceptance.
  - `send_req` in the `frame_done` cycle is ignored.
- UART model that never raises `tx_busy`: after the first `tx_en`, `frame_err` pulses after ACK_TIMEOUT cycles, `busy` drops, and no further `tx_en` occurs.
- `rst_n` low for 1 cycle while the 6th byte is in DONE:
  - All outputs return to reset values.
  - No `frame_done` or `frame_err` is produced.
  - A new request afterwards produces a complete, correct frame starting at `S`.
